// File: rtl/sort_stream_pkg.sv
//------------------------------------------------------------------------------
// Module   : sort_stream_pkg
// Brief    : Shared word type and sizing helper for the sort stream channels.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sort_stream_pkg;

  localparam int WORD_W = 32;

  typedef logic signed [WORD_W-1:0] word_t;

  // Bits needed to hold an occupancy value in 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sort_stream_fifo_mem.sv
//------------------------------------------------------------------------------
// Module   : sort_stream_fifo_mem
// Brief    : DEPTH x WIDTH register array, one synchronous write port and one
//            asynchronous read port. No reset, no control.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sort_stream_fifo_mem #(
  parameter int DEPTH  = 2,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 1
) (
  input  logic              ap_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/sort_stream_fifo.sv
//------------------------------------------------------------------------------
// Module   : sort_stream_fifo
// Brief    : Show-ahead stream FIFO between insertion-sort cells. Optional
//            high-watermark output enabled by SORT_STREAM_FIFO_PEAK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sort_stream_fifo
  import sort_stream_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WORD_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [WIDTH-1:0]          if_din,
  output logic                      if_full_n,
  input  logic                      if_write,
  output logic [WIDTH-1:0]          if_dout,
  output logic                      if_empty_n,
  input  logic                      if_read
`ifdef SORT_STREAM_FIFO_PEAK_EN
  ,
  output logic [count_w(DEPTH)-1:0] peak_count
`endif
);

  localparam int c_cnt_w = count_w(DEPTH);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_max = c_ptr_w'(DEPTH - 1);

  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic               w_wr_en;
  logic               w_rd_en;

  // Flags decode registered state only; requests never reach them combinationally.
  assign if_full_n  = (r_count != c_depth);
  assign if_empty_n = (r_count != '0);

  assign w_wr_en = if_write & if_full_n & ~ap_rst;
  assign w_rd_en = if_read & if_empty_n & ~ap_rst;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_en && !w_rd_en) begin
      w_count_nxt = r_count + c_cnt_w'(1);
    end else if (w_rd_en && !w_wr_en) begin
      w_count_nxt = r_count - c_cnt_w'(1);
    end
  end

  // Explicit wrap compare so non-power-of-two depths work.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_max) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_max) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  sort_stream_fifo_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (c_ptr_w)
  ) u_mem (
    .ap_clk  (ap_clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_wr_ptr),
    .wr_data (if_din),
    .rd_addr (r_rd_ptr),
    .rd_data (if_dout)
  );

`ifdef SORT_STREAM_FIFO_PEAK_EN
  logic [c_cnt_w-1:0] r_peak;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_peak <= '0;
    end else if (w_count_nxt > r_peak) begin
      r_peak <= w_count_nxt;
    end
  end

  assign peak_count = r_peak;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sort_stream_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_sort_stream_fifo
// Brief    : Self-checking bench for sort_stream_fifo at DEPTH = 4.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sort_stream_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             ap_clk   = 1'b0;
  logic             ap_rst   = 1'b0;
  logic             if_write = 1'b0;
  logic             if_read  = 1'b0;
  logic [WIDTH-1:0] if_din   = '0;
  logic [WIDTH-1:0] if_dout;
  logic             if_full_n;
  logic             if_empty_n;
`ifdef SORT_STREAM_FIFO_PEAK_EN
  logic [CW-1:0]    peak_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];
  int m_cnt  = 0;
  int m_peak = 0;

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] din;
    logic        exp_e;
    logic        exp_f;
  } vec_t;

  vec_t vt[10];

  sort_stream_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .if_din     (if_din),
    .if_full_n  (if_full_n),
    .if_write   (if_write),
    .if_dout    (if_dout),
    .if_empty_n (if_empty_n),
    .if_read    (if_read)
`ifdef SORT_STREAM_FIFO_PEAK_EN
    ,
    .peak_count (peak_count)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, " empty_n"}, 32'(if_empty_n), 32'(m_cnt != 0));
    chk({tag, " full_n"}, 32'(if_full_n), 32'(m_cnt != DEPTH));
`ifdef SORT_STREAM_FIFO_PEAK_EN
    chk({tag, " peak"}, 32'(peak_count), 32'(m_peak));
`endif
  endtask

  // One clock of stimulus; the scoreboard predicts acceptance from its own count.
  task automatic step(input logic w, input logic r, input logic [31:0] d, input string tag);
    bit wr_ok;
    bit rd_ok;
    @(negedge ap_clk);
    if_write = w;
    if_read  = r;
    if_din   = d;
    wr_ok = w && (m_cnt < DEPTH);
    rd_ok = r && (m_cnt > 0);
    #1;
    if (rd_ok) chk({tag, " dout"}, if_dout, sb[0]);
    @(posedge ap_clk);
    if (rd_ok) void'(sb.pop_front());
    if (wr_ok) sb.push_back(d);
    m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
    if (m_cnt > m_peak) m_peak = m_cnt;
    #1;
    if_write = 1'b0;
    if_read  = 1'b0;
    chk_flags(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'd7,          1'b1, 1'b1};
    vt[1] = '{1'b1, 1'b0, 32'hFFFF_FFFD,  1'b1, 1'b1};
    vt[2] = '{1'b1, 1'b0, 32'd12,         1'b1, 1'b1};
    vt[3] = '{1'b1, 1'b0, 32'd5,          1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'd99,         1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b1, 32'd0,          1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b1, 32'd0,          1'b1, 1'b1};
    vt[7] = '{1'b0, 1'b1, 32'd0,          1'b1, 1'b1};
    vt[8] = '{1'b0, 1'b1, 32'd0,          1'b0, 1'b1};
    vt[9] = '{1'b0, 1'b1, 32'd0,          1'b0, 1'b1};

    #1 ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1 chk_flags("reset");

    for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 32'd0, "idle");

    // Fill, overfill, drain, overdrain.
    for (int i = 0; i < 10; i++) begin
      step(vt[i].w, vt[i].r, vt[i].din, "tbl");
      chk("tbl exp empty_n", 32'(if_empty_n), 32'(vt[i].exp_e));
      chk("tbl exp full_n", 32'(if_full_n), 32'(vt[i].exp_f));
    end

    // Sustained write+read at count 2.
    step(1'b1, 1'b0, 32'd100, "stream pre");
    step(1'b1, 1'b0, 32'd101, "stream pre");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'(200 + i), "stream");
    step(1'b0, 1'b1, 32'd0, "stream drain");
    step(1'b0, 1'b1, 32'd0, "stream drain");

    // Write+read on empty: no bypass, write lands.
    step(1'b1, 1'b1, 32'h11, "wr_rd_empty");
    chk("wr_rd_empty dout", if_dout, 32'h11);
    step(1'b1, 1'b0, 32'hA1, "fill");
    step(1'b1, 1'b0, 32'hA2, "fill");
    step(1'b1, 1'b0, 32'hA3, "fill");
    chk("fill full_n", 32'(if_full_n), 32'd0);
    // Write+read on full: read only.
    step(1'b1, 1'b1, 32'h22, "wr_rd_full");
    chk("wr_rd_full full_n", 32'(if_full_n), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'd0, "full drain");
    chk("full drain empty_n", 32'(if_empty_n), 32'd0);

    // Pointer wrap with low occupancy.
    step(1'b1, 1'b0, 32'd1, "wrap");
    step(1'b1, 1'b0, 32'd2, "wrap");
    for (int v = 3; v <= 10; v++) step(1'b1, 1'b1, 32'(v), "wrap");
    step(1'b0, 1'b1, 32'd0, "wrap");
    chk("wrap last dout", if_dout, 32'd10);
    step(1'b0, 1'b1, 32'd0, "wrap");

    // Asynchronous reset mid-stream at count 3.
    step(1'b1, 1'b0, 32'h31, "prerst");
    step(1'b1, 1'b0, 32'h32, "prerst");
    step(1'b1, 1'b0, 32'h33, "prerst");
    @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    sb.delete();
    m_cnt  = 0;
    m_peak = 0;
    #1 chk_flags("async_rst");
    if_write = 1'b1;
    if_read  = 1'b1;
    if_din   = 32'h77;
    @(posedge ap_clk);
    #1 chk_flags("rst_hold");
    @(negedge ap_clk);
    ap_rst   = 1'b0;
    if_write = 1'b0;
    if_read  = 1'b0;
    #1 chk_flags("rst_release");
    step(1'b1, 1'b0, 32'h5A, "post_rst");
    chk("post_rst dout", if_dout, 32'h5A);
    step(1'b0, 1'b1, 32'd0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sort_stream_fifo.md
# sort_stream_fifo

Point-to-point stream channel between insertion-sort cells in the dataflow chain. It sits on the other end of each cell's stream handshakes: the writer side accepts `din`/`write` from the upstream cell and reports `full_n`; the reader side presents `dout`/`empty_n` to the downstream cell and consumes on `read`. Data is show-ahead: the head word is valid on `if_dout` whenever `if_empty_n` is high, so a consumer can compare it combinationally before committing the read.

## Interface
- `DEPTH`, 2, number of storage words; any integer ≥ 2, power of two not required
- `WIDTH`, 32, word width in bits (signed sort keys)
- `ap_clk` input 1 — sole clock, rising edge
- `ap_rst` input 1 — reset, asynchronous, active-high
- `if_din` input WIDTH — write data
- `if_full_n` output 1 — high when a write can be accepted
- `if_write` input 1 — write request
- `if_dout` output WIDTH — head-of-queue word, valid while `if_empty_n` = 1
- `if_empty_n` output 1 — high when at least one word is stored
- `if_read` input 1 — read request
- `peak_count` output clog2(DEPTH+1) — high-watermark; present only with `SORT_STREAM_FIFO_PEAK_EN`

## Operation
- State: `wr_ptr`, `rd_ptr` in 0..DEPTH-1; `count` in 0..DEPTH.
- Write accepted iff `if_write & if_full_n`: mem[wr_ptr] <= `if_din`; wr_ptr advances.
- Read accepted iff `if_read & if_empty_n`: rd_ptr advances; word is discarded.
- Pointer wrap: DEPTH-1 -> 0 (explicit compare, not a power-of-two mask).
- count: +1 on write only, −1 on read only, unchanged on both or neither.
- `if_full_n` = (count != DEPTH); `if_empty_n` = (count != 0). Both are registered-state decodes with no combinational path from `if_write`/`if_read`.
- `if_dout` = mem[rd_ptr] (asynchronous read of storage). When empty, the value is don't-care.
- Boundary cases:
  - Write while full: ignored; data is lost by the writer's contract violation and state is unchanged.
  - Read while empty: ignored.
  - Write and read together while empty: only the write takes effect. There is no bypass.
  - Write and read together while full: only the read takes effect.
  - Write and read together at 0 < count < DEPTH: both take effect; count holds.
- Reset, asserted at any time, including mid-transfer: pointers and count go to 0 immediately; stored data is not cleared. While `ap_rst` = 1, all requests are ignored.

## Timing
- Reset values: `if_empty_n` = 0, `if_full_n` = 1, `peak_count` = 0, `if_dout` = X.
- Write-to-read latency is 1 cycle. A word written at edge N drives `if_empty_n` = 1 and appears on `if_dout` after edge N.
- Full-to-not-full: after an accepted read at edge N, `if_full_n` rises after edge N.
- Sustained throughput is one write and one read per cycle at 0 < count < DEPTH.
- Ordering is strict FIFO.

## Configuration
- `SORT_STREAM_FIFO_PEAK_EN` defined:
  - `peak_count` port exists.
  - Register updates to count_next whenever count_next > peak_count.
  - Cleared only by reset; saturates naturally at DEPTH.
- Not defined: port and register are absent; behaviour is otherwise identical.

## Structure
- Shared package `sort_stream_pkg`:
  - `WORD_W` = 32
  - `word_t` (signed [WORD_W-1:0])
  - `count_w(depth)` function returning clog2(depth+1)
- Sub-module `sort_stream_fifo_mem`: DEPTH × WIDTH register array with one synchronous write port and one asynchronous read port. It holds no reset and no control logic.
- Pointer, count and flag logic stays in `sort_stream_fifo`.

## Test plan
- Reset then idle: `if_empty_n` = 0, `if_full_n` = 1 and `peak_count` = 0 for 10 cycles; `if_read` pulses are ignored.
- DEPTH = 4:
  - Write 7, −3, 12, 5 on consecutive cycles -> `if_full_n` = 0 after the 4th edge. A 5th write of 99 is dropped. Reads return 7, −3, 12, 5, then `if_empty_n` = 0.
  - Simultaneous write and read every cycle at count = 2 for 20 cycles -> count stays 2, `if_full_n` = `if_empty_n` = 1, data in order.
  - Write 0x11 and read together on an empty FIFO -> next cycle `if_empty_n` = 1 and `if_dout` = 0x11. Simultaneous write 0x22 and read while full -> read commits, 0x22 is dropped, `if_full_n` = 1.
  - Pointer wrap: push and pop 10 words 1..10 with occupancy ≤ 3 -> output sequence 1..10 exact.
  - Assert `ap_rst` asynchronously, between edges, at count = 3 -> flags go to reset values before the next edge and `peak_count` returns to 0. After release, a write of 0x5A is read back as 0x5A.
